// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, 8-byte little-endian data memory
// and W pipeline register, with M/m values exposed for forwarding.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  e_status,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_bubble,
  input  logic        W_stall,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [1:0]  m_status,
  output logic [1:0]  W_status,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [1:0]  ST_AOK    = 2'd0;
  localparam logic [1:0]  ST_ADR    = 2'd2;
  localparam logic [3:0]  IC_NOP    = 4'h1;
  localparam logic [3:0]  REG_NONE  = 4'hF;

  logic [1:0]    M_status;
  logic [7:0]    mem [MEM_BYTES];
  logic [63:0]   addr;
  logic          rd;
  logic          wr;
  logic          addr_err;
  logic          wr_en;
  logic [AW-1:0] base;

  // Address source and access direction decoded from the M icode
  always_comb begin
    addr = 64'd0;
    rd   = 1'b0;
    wr   = 1'b0;
    case (M_icode)
      4'h4: begin addr = M_valE; wr = 1'b1; end
      4'h5: begin addr = M_valE; rd = 1'b1; end
      4'h8: begin addr = M_valE; wr = 1'b1; end
      4'hA: begin addr = M_valE; wr = 1'b1; end
      4'h9: begin addr = M_valA; rd = 1'b1; end
      4'hB: begin addr = M_valA; rd = 1'b1; end
      default: begin addr = 64'd0; rd = 1'b0; wr = 1'b0; end
    endcase
  end

  // Full 64-bit compare so huge addresses never alias into the array
  assign addr_err = (rd | wr) && (addr > LAST_ADDR);
  assign base     = addr[AW-1:0];
  assign wr_en    = wr && (M_status == ST_AOK) && !addr_err &&
                    (W_status == ST_AOK) && !rst;

  // Combinational 8-byte little-endian read and stage status
  always_comb begin
    m_valM   = 64'd0;
    m_status = M_status;
    if (rd && !addr_err) begin
      for (int i = 0; i < 8; i++) begin
        m_valM[8*i +: 8] = mem[base + AW'(i)];
      end
    end else begin
      m_valM = 64'd0;
    end
    if (addr_err) begin
      m_status = ST_ADR;
    end else begin
      m_status = M_status;
    end
  end

  // Memory write commit from the current M contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  // M pipeline register: reset and bubble both insert a nop
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      M_status <= ST_AOK;
      M_icode  <= IC_NOP;
      M_Cnd    <= 1'b0;
      M_valE   <= 64'd0;
      M_valA   <= 64'd0;
      M_dstE   <= REG_NONE;
      M_dstM   <= REG_NONE;
    end else begin
      M_status <= e_status;
      M_icode  <= e_icode;
      M_Cnd    <= e_Cnd;
      M_valE   <= e_valE;
      M_valA   <= e_valA;
      M_dstE   <= e_dstE;
      M_dstM   <= e_dstM;
    end
  end

  // W pipeline register with stall hold
  always_ff @(posedge clk) begin
    if (rst) begin
      W_status <= ST_AOK;
      W_icode  <= IC_NOP;
      W_valE   <= 64'd0;
      W_valM   <= 64'd0;
      W_dstE   <= REG_NONE;
      W_dstM   <= REG_NONE;
    end else if (!W_stall) begin
      W_status <= m_status;
      W_icode  <= M_icode;
      W_valE   <= M_valE;
      W_valM   <= m_valM;
      W_dstE   <= M_dstE;
      W_dstM   <= M_dstM;
    end
  end

endmodule
